// File: rtl/register_bank_pkg.sv
// Shared constants and types for the register bank with per-register busy scoreboard.
package register_bank_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int DEFAULT_DEPTH  = 2 ** DEFAULT_ADDR_W;

  typedef logic [DEFAULT_DEPTH-1:0] busy_vec_t;

endpackage : register_bank_pkg

// File: rtl/register_bank_scoreboard.sv
// Per-register pending (busy) bits with set/clear priority and two registered lookups
// that report the post-edge busy state of the looked-up register.
module register_bank_scoreboard
  import register_bank_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] look_addr1,
  input  logic [ADDR_W-1:0] look_addr2,
  output logic              busy1,
  output logic              busy2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             busy1_q;
  logic             busy1_d;
  logic             busy2_q;
  logic             busy2_d;

  // Set is applied after clear so a same-edge reservation wins over the write.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_addr] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (set_en) begin
      busy_d[set_addr] = 1'b1;
    end else begin
      busy_d[set_addr] = busy_d[set_addr];
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end else begin
      busy_d[0] = busy_d[0];
    end
    busy1_d = busy_d[look_addr1];
    busy2_d = busy_d[look_addr2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      busy1_q <= 1'b0;
      busy2_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      busy1_q <= busy1_d;
      busy2_q <= busy2_d;
    end
  end

  assign busy1 = busy1_q;
  assign busy2 = busy2_q;

endmodule : register_bank_scoreboard

// File: rtl/register_bank_sb.sv
// Two-read/one-write register bank with optional zero register, optional write-to-read
// forwarding and a busy scoreboard; read data and busy flags are registered.
module register_bank_sb
  import register_bank_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd_data1_q;
  logic [DATA_W-1:0] rd_data1_d;
  logic [DATA_W-1:0] rd_data2_q;
  logic [DATA_W-1:0] rd_data2_d;
  logic              wr_commit;
  logic              rsv_commit;
  logic              rd1_zero;
  logic              rd2_zero;

  assign wr_commit  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == {ADDR_W{1'b0}}));
  assign rsv_commit = rsv_en && !((ZERO_REG != 0) && (rsv_addr == {ADDR_W{1'b0}}));
  assign rd1_zero   = (ZERO_REG != 0) && (rd_addr1 == {ADDR_W{1'b0}});
  assign rd2_zero   = (ZERO_REG != 0) && (rd_addr2 == {ADDR_W{1'b0}});

  // Forwarding reads the post-write image; without it the pre-write contents are shown.
  always_comb begin
    mem_d = mem_q;
    if (wr_commit) begin
      mem_d[wr_addr] = wr_data;
    end else begin
      mem_d = mem_q;
    end
    if (rd1_zero) begin
      rd_data1_d = {DATA_W{1'b0}};
    end else if (BYPASS != 0) begin
      rd_data1_d = mem_d[rd_addr1];
    end else begin
      rd_data1_d = mem_q[rd_addr1];
    end
    if (rd2_zero) begin
      rd_data2_d = {DATA_W{1'b0}};
    end else if (BYPASS != 0) begin
      rd_data2_d = mem_d[rd_addr2];
    end else begin
      rd_data2_d = mem_q[rd_addr2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
      rd_data1_q <= {DATA_W{1'b0}};
      rd_data2_q <= {DATA_W{1'b0}};
    end else begin
      mem_q      <= mem_d;
      rd_data1_q <= rd_data1_d;
      rd_data2_q <= rd_data2_d;
    end
  end

  register_bank_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en     (rsv_commit),
    .set_addr   (rsv_addr),
    .clr_en     (wr_commit),
    .clr_addr   (wr_addr),
    .look_addr1 (rd_addr1),
    .look_addr2 (rd_addr2),
    .busy1      (rd_busy1),
    .busy2      (rd_busy2)
  );

  assign rd_data1 = rd_data1_q;
  assign rd_data2 = rd_data2_q;

endmodule : register_bank_sb

// File: tb/tb_register_bank_sb.sv
// Bench for register_bank_sb: a forwarding and a non-forwarding instance share stimulus and
// are checked every cycle against an array model, plus directed literal expectations.
module tb_register_bank_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;

  logic [31:0] b_d1, b_d2, n_d1, n_d2;
  logic        b_y1, b_y2, n_y1, n_y2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  register_bank_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_data1(b_d1), .rd_data2(b_d2), .rd_busy1(b_y1), .rd_busy2(b_y2)
  );

  register_bank_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nob (
    .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_data1(n_d1), .rd_data2(n_d2), .rd_busy1(n_y1), .rd_busy2(n_y2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: register image and busy set; expectations derived from before/after images.
  logic [31:0] m_mem [32];
  logic [31:0] old_mem [32];
  logic        m_busy [32];
  logic [31:0] e_b1, e_b2, e_n1, e_n2;
  logic        e_y1, e_y2;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = 32'h0;
        m_busy[i] = 1'b0;
      end
      e_b1 = 32'h0; e_b2 = 32'h0; e_n1 = 32'h0; e_n2 = 32'h0;
      e_y1 = 1'b0;  e_y2 = 1'b0;
      chk_en = 1'b1;
    end else begin
      old_mem = m_mem;
      if (wr_en && wr_addr != 5'd0) begin
        m_mem[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
      e_b1 = m_mem[rd_addr1];
      e_b2 = m_mem[rd_addr2];
      e_n1 = old_mem[rd_addr1];
      e_n2 = old_mem[rd_addr2];
      e_y1 = m_busy[rd_addr1];
      e_y2 = m_busy[rd_addr2];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("byp_d1", b_d1, e_b1);
      chk("byp_d2", b_d2, e_b2);
      chk("byp_y1", {31'h0, b_y1}, {31'h0, e_y1});
      chk("byp_y2", {31'h0, b_y2}, {31'h0, e_y2});
      chk("nob_d1", n_d1, e_n1);
      chk("nob_d2", n_d2, e_n2);
      chk("nob_y1", {31'h0, n_y1}, {31'h0, e_y1});
      chk("nob_y2", {31'h0, n_y2}, {31'h0, e_y2});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0;
    wr_addr = 5'd0; rsv_addr = 5'd0; wr_data = 32'h0;
  endtask

  initial begin
    rst = 1'b1; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    idle();
    cyc(); cyc();
    rst = 1'b0;

    // Reset state across every address, ports swept in opposite directions.
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i); rd_addr2 = 5'(31 - i);
      cyc();
      chk("rst_d1", b_d1, 32'h0);
      chk("rst_d2", b_d2, 32'h0);
      chk("rst_y1", {31'h0, b_y1}, 32'h0);
      chk("rst_y2", {31'h0, b_y2}, 32'h0);
    end

    // Write then read on both ports.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF; rd_addr1 = 5'd1; rd_addr2 = 5'd2;
    cyc();
    idle(); rd_addr1 = 5'd7; rd_addr2 = 5'd7;
    cyc();
    chk("wr_rd_p1", b_d1, 32'hDEADBEEF);
    chk("wr_rd_p2", b_d2, 32'hDEADBEEF);
    chk("wr_rd_nob", n_d1, 32'hDEADBEEF);

    // Forwarding: old r3 value, then same-edge write and read.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h11111111;
    cyc();
    wr_data = 32'h12345678; rd_addr1 = 5'd3; rd_addr2 = 5'd7;
    cyc();
    chk("bypass_on", b_d1, 32'h12345678);
    chk("bypass_off", n_d1, 32'h11111111);
    idle();
    cyc();
    chk("after_byp_off", n_d1, 32'h12345678);

    // Zero register: write and reserve are ignored, even with same-edge forwarding.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    rsv_en = 1'b1; rsv_addr = 5'd0; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    cyc();
    chk("zero_same_d", b_d1, 32'h0);
    chk("zero_same_y", {31'h0, b_y1}, 32'h0);
    idle();
    cyc();
    chk("zero_d", b_d2, 32'h0);
    chk("zero_y", {31'h0, b_y2}, 32'h0);

    // Scoreboard: reserve, clear by write, then reserve+write on the same edge.
    rsv_en = 1'b1; rsv_addr = 5'd5; rd_addr1 = 5'd5; rd_addr2 = 5'd6;
    cyc();
    chk("sb_rsv", {31'h0, b_y1}, 32'h1);
    chk("sb_other", {31'h0, b_y2}, 32'h0);
    idle(); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h000000A5;
    cyc();
    chk("sb_clr", {31'h0, b_y1}, 32'h0);
    chk("sb_clr_d", b_d1, 32'h000000A5);
    rsv_en = 1'b1; rsv_addr = 5'd5; rd_addr2 = 5'd5;
    cyc();
    chk("sb_both_y", {31'h0, b_y1}, 32'h1);
    chk("sb_both_y2", {31'h0, n_y2}, 32'h1);
    chk("sb_both_d", b_d1, 32'h000000A5);
    idle();
    cyc();
    chk("sb_hold_y", {31'h0, b_y2}, 32'h1);

    // Mixed traffic: reserve one register while writing another.
    for (int i = 8; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'h1000_0000 + 32'(i * 3);
      rsv_en = 1'b1; rsv_addr = 5'(i + 8);
      rd_addr1 = 5'(i); rd_addr2 = 5'(i + 7);
      cyc();
    end
    idle(); rd_addr1 = 5'd16; rd_addr2 = 5'd12;
    cyc();
    chk("mix_busy16", {31'h0, b_y1}, 32'h1);
    chk("mix_d12", b_d2, 32'h10000024);

    // Reset mid-operation discards a same-edge write and reserve.
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00000055;
    cyc();
    rst = 1'b1; wr_data = 32'h00000066; rsv_en = 1'b1; rsv_addr = 5'd9; rd_addr1 = 5'd9;
    cyc();
    rst = 1'b0; idle(); rd_addr1 = 5'd9; rd_addr2 = 5'd7;
    cyc();
    chk("rst_mid_d", b_d1, 32'h0);
    chk("rst_mid_y", {31'h0, b_y1}, 32'h0);
    chk("rst_mid_r7", b_d2, 32'h0);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00000077;
    cyc();
    chk("resume_d", b_d1, 32'h00000077);
    idle();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_register_bank_sb

// File: doc/register_bank_sb.md
REGISTER_BANK_SB -- requirements
Module: register_bank_sb

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register data width in bits.
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width; the depth SHALL be 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 1, SHALL make register 0 read as zero, ignore writes to it and never mark it busy when set to 1.
REQ-004 Parameter BYPASS, default 1, SHALL enable write-to-read forwarding when set to 1.
REQ-005 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst, input, 1, SHALL be the synchronous, active-high reset.
REQ-007 Port rd_addr1 / rd_addr2, input, ADDR_W each, SHALL be the read-port addresses.
REQ-008 Port wr_en, input, 1, SHALL be the write strobe.
REQ-009 Port wr_addr, input, ADDR_W, SHALL be the write destination.
REQ-010 Port wr_data, input, DATA_W, SHALL be the write value.
REQ-011 Port rsv_en, input, 1, SHALL be the reserve (mark-pending) strobe.
REQ-012 Port rsv_addr, input, ADDR_W, SHALL be the register to reserve.
REQ-013 Port rd_data1 / rd_data2, output, DATA_W each, SHALL be the registered read data.
REQ-014 Port rd_busy1 / rd_busy2, output, 1 each, SHALL be the registered pending flags for the read addresses.

Function
REQ-015 Writes SHALL commit on the rising edge when wr_en=1 and wr_addr is not protected by ZERO_REG.
REQ-016 Read latency SHALL be one cycle: rd_dataN SHALL reflect the addresses sampled at edge k, and SHALL be valid after edge k.
REQ-017 With BYPASS=1, if wr_en=1 and wr_addr=rd_addrN at edge k, rd_dataN SHALL equal wr_data after edge k; with BYPASS=0 it SHALL show the old contents.
REQ-018 With ZERO_REG=1, reads of address 0 SHALL return 0 even if bypass conditions hold.
REQ-019 Each register SHALL have a busy bit: rsv_en sets busy[rsv_addr]; a committed write clears busy[wr_addr].
REQ-020 When rsv_en and wr_en target the same address at the same edge, busy SHALL end set, because the new reservation wins; the data write SHALL still commit.
REQ-021 rd_busyN SHALL equal the post-edge busy value of the sampled rd_addrN, so a same-edge write or reserve is visible.
REQ-022 Both read ports SHALL operate independently; identical addresses on both SHALL return identical data and busy values.
REQ-023 Reserve or write to address 0 with ZERO_REG=1 SHALL have no effect.

Reset
REQ-024 With rst=1 at an edge, all registers, all busy bits, rd_data1/2 and rd_busy1/2 SHALL become 0; this SHALL take priority over wr_en and rsv_en on the same edge.
REQ-025 A write or reserve issued on the reset edge SHALL be discarded; operation SHALL resume on the first edge with rst=0.

Structure
REQ-026 Package register_bank_pkg SHALL hold the default DATA_W and ADDR_W constants and the busy-vector typedef.
REQ-027 The busy-bit logic SHALL be a sub-module, register_bank_scoreboard, containing set, clear and priority logic and the two lookup ports.
REQ-028 Storage SHALL be a flop array sized by the parameters, with no vendor primitives.

Verification
REQ-029 The bench SHALL check reset: rst=1 for 2 cycles, then read addresses 0..31; every rd_data SHALL be 0 and every rd_busy SHALL be 0.
REQ-030 The bench SHALL check write then read: write 0xDEADBEEF to r7, and one cycle later read r7 on both ports; both SHALL return 0xDEADBEEF.
REQ-031 The bench SHALL check bypass: write 0x12345678 to r3 with rd_addr1=3 on the same edge; rd_data1 SHALL be 0x12345678 next cycle with BYPASS=1 and the old value with BYPASS=0.
REQ-032 The bench SHALL check the zero register: write 0xFFFFFFFF and reserve r0; a read of r0 SHALL return 0 with rd_busy=0.
REQ-033 The bench SHALL check the scoreboard: reserve r5, so rd_busy for r5 is 1; write r5 with 0xA5, so busy is 0; then reserve and write r5 on the same edge, so busy is 1 and data is 0xA5.
REQ-034 The bench SHALL check reset mid-operation: after writing r9=0x55, assert rst together with wr_en to r9=0x66; a read of r9 after reset SHALL return 0.
